// File: rtl/mant_sub_norm_25_if.sv
// Handshake and operand/result bundle for the mantissa subtract-and-normalize unit.
interface mant_sub_norm_25_if #(
    parameter int WIDTH = 25,
    parameter int EXP_W = 8
);
    logic             start;
    logic             ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [EXP_W-1:0] exp_in;
    logic             done;
    logic [WIDTH-1:0] res;
    logic [EXP_W-1:0] exp_out;
    logic             sign;
    logic             zero;
    logic             uf;

    modport master (
        output start, a, b, exp_in,
        input  ready, done, res, exp_out, sign, zero, uf
    );

    modport slave (
        input  start, a, b, exp_in,
        output ready, done, res, exp_out, sign, zero, uf
    );
endinterface

// File: rtl/mant_sub_norm_25.sv
// Computes |A-B| with sign, then left-normalizes one bit per cycle while decrementing the exponent.
// Latency k+3 cycles from accept (k = shifts); START ignored unless READY, results hold until next accept.
module mant_sub_norm_25 #(
    parameter int WIDTH = 25,
    parameter int EXP_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mant_sub_norm_25_if.slave    bus
);
    typedef enum logic [1:0] {S_IDLE, S_SUB, S_NORM, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, r;
    logic [EXP_W-1:0] e;
    logic [WIDTH:0]   diff;
    logic             norm_end;

    // Extra top bit of the subtraction is the borrow-free carry: set when A >= B.
    always_comb begin
        diff = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    end

    assign norm_end = (r == '0) || r[WIDTH-1] || (e == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_SUB;
            S_SUB:   state_nxt = S_NORM;
            S_NORM:  if (norm_end) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ready = (state == S_IDLE);
        bus.done  = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            r           <= '0;
            e           <= '0;
            bus.res     <= '0;
            bus.exp_out <= '0;
            bus.sign    <= 1'b0;
            bus.zero    <= 1'b0;
            bus.uf      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    a_q      <= bus.a;
                    b_q      <= bus.b;
                    e        <= bus.exp_in;
                    bus.sign <= 1'b0;
                    bus.zero <= 1'b0;
                    bus.uf   <= 1'b0;
                end
                S_SUB: begin
                    if (diff[WIDTH]) begin
                        r        <= diff[WIDTH-1:0];
                        bus.sign <= 1'b0;
                    end else begin
                        r        <= ~diff[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, 1'b1};
                        bus.sign <= 1'b1;
                    end
                end
                S_NORM: begin
                    if (r == '0) begin
                        bus.zero    <= 1'b1;
                        bus.sign    <= 1'b0;
                        bus.exp_out <= '0;
                        bus.res     <= '0;
                    end else if (r[WIDTH-1]) begin
                        bus.res     <= r;
                        bus.exp_out <= e;
                        bus.uf      <= 1'b0;
                    end else if (e == '0) begin
                        // Exponent exhausted: hand on a denormal rather than wrap below zero.
                        bus.res     <= r;
                        bus.exp_out <= '0;
                        bus.uf      <= 1'b1;
                    end else begin
                        r <= r << 1;
                        e <= e - {{(EXP_W-1){1'b0}}, 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mant_sub_norm_25.sv
// Directed-vector bench for mant_sub_norm_25: latency, results, busy-START, reset mid-op, back-to-back.
module tb_mant_sub_norm_25;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mant_sub_norm_25_if #(.WIDTH(25), .EXP_W(8)) bus ();

    mant_sub_norm_25 #(.WIDTH(25), .EXP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Called at posedge+1 in IDLE; returns at posedge+1 just after the accept edge.
    task automatic start_op(input logic [24:0] av, input logic [24:0] bv, input logic [7:0] ev);
        bus.a = av; bus.b = bv; bus.exp_in = ev; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // lat = cycle index (accept cycle = 0) in which DONE is first seen; 60 on timeout.
    task automatic wait_done(output int lat);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.start = 1'b1;
        bus.a = 25'h1000000; bus.b = 25'h0; bus.exp_in = 8'd10;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; bus.start = 1'b0;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if ({bus.res, bus.exp_out, bus.sign, bus.zero, bus.uf} !== 36'h0)
            begin errors++; $display("FAIL reset_outputs res=%h exp=%0d s=%b z=%b uf=%b exp_all=0", bus.res, bus.exp_out, bus.sign, bus.zero, bus.uf); end
        @(posedge clk); #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_start_ignored ready=%b exp=1", bus.ready); end
    endtask

    task automatic test_basic;
        int lat;
        start_op(25'h1000000, 25'h0800000, 8'd100);
        wait_done(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        checks++; if (bus.res !== 25'h1000000) begin errors++; $display("FAIL basic_res got=%h exp=1000000", bus.res); end
        checks++; if (bus.exp_out !== 8'd99) begin errors++; $display("FAIL basic_exp got=%0d exp=99", bus.exp_out); end
        checks++; if ({bus.sign, bus.zero, bus.uf} !== 3'b000) begin errors++; $display("FAIL basic_flags got=%b exp=000", {bus.sign, bus.zero, bus.uf}); end
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL basic_ready_in_done got=%b exp=0", bus.ready); end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin errors++; $display("FAIL basic_done_pulse done=%b ready=%b exp=0/1", bus.done, bus.ready); end
        checks++; if (bus.res !== 25'h1000000) begin errors++; $display("FAIL basic_res_hold got=%h exp=1000000", bus.res); end
    endtask

    task automatic test_swapped;
        int lat;
        start_op(25'h0800000, 25'h1000000, 8'd100);
        wait_done(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL swap_latency got=%0d exp=4", lat); end
        checks++; if (bus.res !== 25'h1000000 || bus.exp_out !== 8'd99)
            begin errors++; $display("FAIL swap_result res=%h exp_out=%0d exp=1000000/99", bus.res, bus.exp_out); end
        checks++; if ({bus.sign, bus.zero, bus.uf} !== 3'b100) begin errors++; $display("FAIL swap_flags got=%b exp=100", {bus.sign, bus.zero, bus.uf}); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero;
        int lat;
        start_op(25'h1234567, 25'h1234567, 8'd50);
        wait_done(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL zero_latency got=%0d exp=3", lat); end
        checks++; if (bus.res !== 25'h0 || bus.exp_out !== 8'd0)
            begin errors++; $display("FAIL zero_result res=%h exp_out=%0d exp=0/0", bus.res, bus.exp_out); end
        checks++; if ({bus.sign, bus.zero, bus.uf} !== 3'b010) begin errors++; $display("FAIL zero_flags got=%b exp=010", {bus.sign, bus.zero, bus.uf}); end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_start;
        int n;
        start_op(25'h1000001, 25'h1000000, 8'd127);
        n = 1;
        while (bus.done !== 1'b1 && n < 60) begin
            if (n == 5) begin
                bus.a = 25'h0000010; bus.b = 25'h0; bus.exp_in = 8'd3; bus.start = 1'b1;
                checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL busy_ready got=%b exp=0", bus.ready); end
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            n++;
        end
        checks++; if (n !== 27) begin errors++; $display("FAIL long_latency got=%0d exp=27", n); end
        checks++; if (bus.res !== 25'h1000000 || bus.exp_out !== 8'd103)
            begin errors++; $display("FAIL long_result res=%h exp_out=%0d exp=1000000/103", bus.res, bus.exp_out); end
        checks++; if ({bus.sign, bus.zero, bus.uf} !== 3'b000) begin errors++; $display("FAIL long_flags got=%b exp=000", {bus.sign, bus.zero, bus.uf}); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL busy_not_queued ready=%b exp=1", bus.ready); end
    endtask

    task automatic test_underflow;
        int lat;
        start_op(25'h0000010, 25'h0, 8'd3);
        wait_done(lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL uf_latency got=%0d exp=6", lat); end
        checks++; if (bus.res !== 25'h0000080 || bus.exp_out !== 8'd0)
            begin errors++; $display("FAIL uf_result res=%h exp_out=%0d exp=0000080/0", bus.res, bus.exp_out); end
        checks++; if ({bus.sign, bus.zero, bus.uf} !== 3'b001) begin errors++; $display("FAIL uf_flags got=%b exp=001", {bus.sign, bus.zero, bus.uf}); end
        @(posedge clk); #1;
    endtask

    task automatic test_exp_zero;
        int lat;
        start_op(25'h0000003, 25'h0000001, 8'd0);
        wait_done(lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL exp0_latency got=%0d exp=3", lat); end
        checks++; if (bus.res !== 25'h0000002 || bus.uf !== 1'b1)
            begin errors++; $display("FAIL exp0_result res=%h uf=%b exp=0000002/1", bus.res, bus.uf); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op;
        int n;
        int seen_done;
        int lat;
        start_op(25'h1000001, 25'h1000000, 8'd127);
        for (n = 1; n < 10; n++) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0)
            begin errors++; $display("FAIL rst_mid_state ready=%b done=%b exp=1/0", bus.ready, bus.done); end
        checks++; if ({bus.res, bus.exp_out, bus.sign, bus.zero, bus.uf} !== 36'h0)
            begin errors++; $display("FAIL rst_mid_outputs res=%h exp_out=%0d exp_all=0", bus.res, bus.exp_out); end
        seen_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) seen_done++;
            @(posedge clk); #1;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d exp=0", seen_done); end
        start_op(25'h1000000, 25'h0800000, 8'd100);
        wait_done(lat);
        checks++; if (lat !== 4 || bus.res !== 25'h1000000 || bus.exp_out !== 8'd99)
            begin errors++; $display("FAIL rst_mid_recover lat=%0d res=%h exp_out=%0d exp=4/1000000/99", lat, bus.res, bus.exp_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int lat;
        bus.a = 25'h1000000; bus.b = 25'h0800000; bus.exp_in = 8'd100; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.a = 25'h0800000; bus.b = 25'h1000000; bus.exp_in = 8'd20;
        wait_done(lat);
        checks++; if (lat !== 4 || bus.sign !== 1'b0 || bus.exp_out !== 8'd99)
            begin errors++; $display("FAIL b2b_first lat=%0d sign=%b exp_out=%0d exp=4/0/99", lat, bus.sign, bus.exp_out); end
        @(posedge clk); #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready got=%b exp=1", bus.ready); end
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=4", lat); end
        checks++; if (bus.res !== 25'h1000000 || bus.exp_out !== 8'd19 || bus.sign !== 1'b1)
            begin errors++; $display("FAIL b2b_second res=%h exp_out=%0d sign=%b exp=1000000/19/1", bus.res, bus.exp_out, bus.sign); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.exp_in = '0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_swapped();
        test_zero();
        test_busy_start();
        test_underflow();
        test_exp_zero();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
